// File: rtl/btn_pkg.sv
// Shared types and helpers for the button scan controller.

`ifndef BTN_PARAM_CHECK
// Elaboration-time parameter legality check; place in a module body.
`define BTN_PARAM_CHECK(cond_, blk_, msg_) \
  if (!(cond_)) begin : blk_ \
    $fatal(1, msg_); \
  end
`endif

package btn_pkg;

  // Per-channel debounce / auto-repeat state.
  typedef enum logic [2:0] {
    ChIdle     = 3'd0,
    ChDebPress = 3'd1,
    ChHeld     = 3'd2,
    ChRepeat   = 3'd3,
    ChDebRel   = 3'd4
  } chan_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Debounced level is high from accepted press until accepted release.
  function automatic logic chan_pressed(input chan_state_t st);
    return (st == ChHeld) || (st == ChRepeat) || (st == ChDebRel);
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Scan-tick prescaler. Starts a channel scan on each tick, remembers one tick that
// arrives while a scan is still running, and flags overrun when a further tick is lost.

module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scan_busy_i,
  output logic scan_start_o,
  output logic overrun_o
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            pend_q, pend_d;
  logic            ovr_q, ovr_d;
  logic            tick;

  // Prescaler wrap, scan start arbitration and pending/overrun bookkeeping.
  always_comb begin
    tick         = (div_q == DivLast);
    div_d        = tick ? '0 : div_q + 1'b1;
    scan_start_o = !scan_busy_i && (tick || pend_q);
    pend_d       = pend_q;
    ovr_d        = ovr_q;
    if (scan_busy_i) begin
      if (tick) begin
        if (pend_q) begin
          ovr_d = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
      end
    end else begin
      // Idle: a pending tick is consumed now; a tick landing in the same cycle waits.
      pend_d = tick && pend_q;
    end
  end

  // Prescaler and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign overrun_o = ovr_q;

endmodule

// File: rtl/btn_scan_ctrl.sv
// Time-multiplexed debounce and auto-repeat controller. One shared update engine
// visits a channel per cycle during a scan and pushes press/repeat events into a
// single valid/ready slot; a full slot stalls the scan on the emitting channel.

module btn_scan_ctrl
  import btn_pkg::*;
#(
  parameter int unsigned N        = 5,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DEB_T    = 10,
  parameter int unsigned DELAY_T  = 400,
  parameter int unsigned RATE_T   = 100,
  parameter int unsigned CW       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           btn_raw,
  output logic [N-1:0]           level,
  output logic                   evt_valid,
  output logic [id_width(N)-1:0] evt_id,
  output logic                   evt_rep,
  input  logic                   evt_ready,
  output logic                   overrun
);

  localparam int unsigned IdW = id_width(N);
  localparam logic [IdW-1:0] PtrLast   = IdW'(N - 1);
  localparam logic [CW-1:0]  DebLast   = CW'(DEB_T - 1);
  localparam logic [CW-1:0]  DelayLast = CW'(DELAY_T - 1);
  localparam logic [CW-1:0]  RateLast  = CW'(RATE_T - 1);
  localparam logic [CW-1:0]  CntOne    = CW'(1);

  `BTN_PARAM_CHECK(N >= 1 && N <= 16, gen_chk_n, "btn_scan_ctrl: N must be 1..16")
  `BTN_PARAM_CHECK(TICK_DIV >= 4 * N, gen_chk_div, "btn_scan_ctrl: TICK_DIV must be >= 4*N")
  `BTN_PARAM_CHECK(DEB_T >= 1 && DELAY_T >= 1 && RATE_T >= 1, gen_chk_t,
                   "btn_scan_ctrl: DEB_T, DELAY_T and RATE_T must be >= 1")
  `BTN_PARAM_CHECK(CW >= 1 && CW < 32 && max3(DEB_T, DELAY_T, RATE_T) < (1 << CW), gen_chk_cw,
                   "btn_scan_ctrl: CW too narrow for DEB_T/DELAY_T/RATE_T")

  // Two-flop synchronizer; only sync2_q feeds the channel logic.
  logic [N-1:0] sync1_q, sync2_q;

  // Per-channel state.
  chan_state_t   state_q [N];
  chan_state_t   state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];

  // Scan pointer.
  logic           act_q, act_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic           scan_start;

  // Event slot.
  logic           evt_valid_q, evt_valid_d;
  logic [IdW-1:0] evt_id_q, evt_id_d;
  logic           evt_rep_q, evt_rep_d;

  // Shared update engine signals.
  chan_state_t   cur_st, upd_st;
  logic [CW-1:0] cur_cnt, upd_cnt;
  logic          cur_s;
  logic          emit, emit_rep;
  logic          slot_wr, commit;

  btn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_busy_i  (act_q),
    .scan_start_o (scan_start),
    .overrun_o    (overrun)
  );

  // Next state of the channel currently under the scan pointer.
  always_comb begin
    cur_st   = state_q[ptr_q];
    cur_cnt  = cnt_q[ptr_q];
    cur_s    = sync2_q[ptr_q];
    upd_st   = cur_st;
    upd_cnt  = cur_cnt;
    emit     = 1'b0;
    emit_rep = 1'b0;
    case (cur_st)
      ChIdle: begin
        if (cur_s) begin
          if (DEB_T == 1) begin
            upd_st  = ChHeld;
            upd_cnt = '0;
            emit    = 1'b1;
          end else begin
            upd_st  = ChDebPress;
            upd_cnt = CntOne;
          end
        end
      end
      ChDebPress: begin
        if (!cur_s) begin
          upd_st  = ChIdle;
          upd_cnt = '0;
        end else if (cur_cnt == DebLast) begin
          upd_st  = ChHeld;
          upd_cnt = '0;
          emit    = 1'b1;
        end else begin
          upd_cnt = cur_cnt + 1'b1;
        end
      end
      ChHeld, ChRepeat: begin
        if (!cur_s) begin
          // With a one-sample debounce the release is accepted immediately.
          upd_st  = (DEB_T == 1) ? ChIdle : ChDebRel;
          upd_cnt = (DEB_T == 1) ? '0 : CntOne;
        end else if (cur_cnt == ((cur_st == ChHeld) ? DelayLast : RateLast)) begin
          upd_st   = ChRepeat;
          upd_cnt  = '0;
          emit     = 1'b1;
          emit_rep = 1'b1;
        end else begin
          upd_cnt = cur_cnt + 1'b1;
        end
      end
      ChDebRel: begin
        if (cur_s) begin
          // Bounce back to pressed restarts the full repeat delay.
          upd_st  = ChHeld;
          upd_cnt = '0;
        end else if (cur_cnt == DebLast) begin
          upd_st  = ChIdle;
          upd_cnt = '0;
        end else begin
          upd_cnt = cur_cnt + 1'b1;
        end
      end
      default: begin
        upd_st  = ChIdle;
        upd_cnt = '0;
      end
    endcase
  end

  // Commit the visited channel unless its event would not fit in the slot.
  always_comb begin
    slot_wr = !evt_valid_q || evt_ready;
    commit  = act_q && !(emit && !slot_wr);
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    if (commit) begin
      state_d[ptr_q] = upd_st;
      cnt_d[ptr_q]   = upd_cnt;
    end
  end

  // Scan pointer: walk 0..N-1, holding while the visited channel stalls.
  always_comb begin
    act_d = act_q;
    ptr_d = ptr_q;
    if (act_q) begin
      if (commit) begin
        if (ptr_q == PtrLast) begin
          act_d = 1'b0;
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end else if (scan_start) begin
      act_d = 1'b1;
      ptr_d = '0;
    end
  end

  // Event slot: load on a committed emit, otherwise drain on handshake.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_rep_d   = evt_rep_q;
    if (commit && emit) begin
      evt_valid_d = 1'b1;
      evt_id_d    = ptr_q;
      evt_rep_d   = emit_rep;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  // All controller state, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ChIdle;
        cnt_q[i]   <= '0;
      end
      act_q       <= 1'b0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_rep_q   <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      act_q       <= act_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_rep_q   <= evt_rep_d;
    end
  end

  // Level tracks the channel state register directly.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      level[i] = chan_pressed(state_q[i]);
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_rep   = evt_rep_q;

endmodule
